// File: rtl/hazard_ctrl_if.sv
// Bus bundle between the pipeline datapath and hazard_ctrl.
// The datapath side (master) drives ID/EX status and receives the
// write enables, flushes, halt flag and stall counter; the controller
// side (slave) does the opposite.
interface hazard_ctrl_if;
    // ID-stage instruction fields
    logic [3:0]  id_opCode;
    logic [3:0]  id_funCode;
    logic [3:0]  id_rs;
    logic [3:0]  id_rt;
    // EX-stage status
    logic [1:0]  ex_memRead;
    logic        ex_regWrite;
    logic [3:0]  ex_rd;
    logic        ex_branch_taken;
    // Pipeline control back to the datapath
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_write;
    logic        idex_flush;
    logic        exmem_flush;
    logic        halted;
    logic [15:0] stall_cycles;

    modport master (
        output id_opCode, id_funCode, id_rs, id_rt,
        output ex_memRead, ex_regWrite, ex_rd, ex_branch_taken,
        input  pc_write, ifid_write, ifid_flush,
        input  idex_write, idex_flush, exmem_flush,
        input  halted, stall_cycles
    );

    modport slave (
        input  id_opCode, id_funCode, id_rs, id_rt,
        input  ex_memRead, ex_regWrite, ex_rd, ex_branch_taken,
        output pc_write, ifid_write, ifid_flush,
        output idex_write, idex_flush, exmem_flush,
        output halted, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and sequencing controller for the 5-stage
// IF/ID/EX/MEM/WB datapath. Generates PC / pipeline-register write
// enables and flushes for load-use stalls, taken-branch flushes,
// multi-cycle multiply/divide occupancy of EX and the halt drain.
//
// Optional build macro: HAZARD_PERF_CNT_EN
//   defined   -> stall_cycles counts cycles with pc_write==0 outside
//                HALTED, saturating at 16'hFFFF
//   undefined -> stall_cycles is tied to zero, no counter logic
//
// state    | meaning
// ---------+---------------------------------------------------------
// RUN      | normal issue; load-use stall, branch flush, halt/muldiv
//          | detection
// MULBUSY  | EX holds a multiply/divide; front end frozen, bubbles
//          | into EX/MEM; cnt counts remaining held cycles
// DRAIN    | Halt left ID; older instructions drain EX/MEM/WB while
//          | bubbles enter ID/EX; a taken branch cancels the halt
// HALTED   | everything frozen; only rst leaves this state
module hazard_ctrl #(
    parameter int unsigned MULDIV_CYCLES = 4,
    parameter int unsigned DRAIN_CYCLES  = 3
) (
    input  logic        clk,
    input  logic        rst,
    hazard_ctrl_if.slave bus
);

    // Reject parameter values the 4-bit shared counter cannot express.
    if (MULDIV_CYCLES < 2 || MULDIV_CYCLES > 15) begin : g_bad_muldiv
        $error("hazard_ctrl: MULDIV_CYCLES must be in 2..15");
    end
    if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15) begin : g_bad_drain
        $error("hazard_ctrl: DRAIN_CYCLES must be in 1..15");
    end

    localparam logic [3:0] MULDIV_LOAD = 4'(MULDIV_CYCLES - 1);
    localparam logic [3:0] DRAIN_LOAD  = 4'(DRAIN_CYCLES - 1);

    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_JMP   = 4'd7;
    localparam logic [3:0] OP_HALT  = 4'd15;
    localparam logic [3:0] FN_MUL   = 4'd4;
    localparam logic [3:0] FN_DIV   = 4'd5;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MULBUSY = 2'd1,
        DRAIN   = 2'd2,
        HALTED  = 2'd3
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       halted_q;

    logic       muldiv;
    logic       halt_id;
    logic       reads_regs;
    logic       rd_match;
    logic       load_use;
    logic       branch;

    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_write;
    logic       idex_flush;
    logic       exmem_flush;

    // ID-stage decode and load-use detection against the EX instruction.
    always_comb begin
        muldiv     = (bus.id_opCode == OP_RTYPE) &&
                     ((bus.id_funCode == FN_MUL) || (bus.id_funCode == FN_DIV));
        halt_id    = (bus.id_opCode == OP_HALT);
        reads_regs = !((bus.id_opCode == OP_JMP) || (bus.id_opCode == OP_HALT));
        rd_match   = (bus.ex_rd == bus.id_rs) || (bus.ex_rd == bus.id_rt);
        load_use   = (bus.ex_memRead != 2'b00) && bus.ex_regWrite &&
                     reads_regs && rd_match;
        branch     = bus.ex_branch_taken;
    end

    // Sequencing FSM with the shared MULBUSY/DRAIN down-counter; halted
    // is set on the same edge that enters HALTED so it is valid from the
    // first HALTED cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            cnt      <= 4'd0;
            halted_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    // A taken branch makes anything in ID wrong-path, and a
                    // load-use stall is simply re-evaluated next cycle.
                    if (branch || load_use) begin
                        state <= RUN;
                    end else if (halt_id) begin
                        state <= DRAIN;
                        cnt   <= DRAIN_LOAD;
                    end else if (muldiv) begin
                        state <= MULBUSY;
                        cnt   <= MULDIV_LOAD;
                    end
                end
                MULBUSY: begin
                    // Branch resolution is impossible here: EX holds the op.
                    if (cnt <= 4'd1) begin
                        state <= RUN;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DRAIN: begin
                    if (branch) begin
                        state <= RUN;
                        cnt   <= 4'd0;
                    end else if (cnt == 4'd0) begin
                        state    <= HALTED;
                        halted_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HALTED: begin
                    state    <= HALTED;
                    halted_q <= 1'b1;
                end
                default: begin
                    state <= RUN;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    // Pipeline enables and flushes from the current state and ID/EX inputs.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_write  = 1'b1;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        case (state)
            RUN: begin
                if (branch) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use || halt_id) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            MULBUSY: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_write  = 1'b0;
                exmem_flush = 1'b1;
            end
            DRAIN: begin
                if (branch) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            HALTED: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_write = 1'b0;
            end
            default: begin
                pc_write = 1'b1;
            end
        endcase
    end

    assign bus.pc_write    = pc_write;
    assign bus.ifid_write  = ifid_write;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_write  = idex_write;
    assign bus.idex_flush  = idex_flush;
    assign bus.exmem_flush = exmem_flush;
    assign bus.halted      = halted_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt;

    // Saturating count of front-end stall cycles; the halted idle time
    // is deliberately excluded.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'h0000;
        end else if (!pc_write && (state != HALTED) && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'h0001;
        end
    end

    assign bus.stall_cycles = stall_cnt;
`else
    assign bus.stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table of single-cycle RUN-state
// decisions plus hand-written multi-cycle sequences (muldiv occupancy,
// halt drain, wrong-path halt, reset mid-MULBUSY). Expected outputs are
// pushed to a queue as each cycle is driven and popped at the negedge.
module tb_hazard_ctrl;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_write;
        logic idex_flush;
        logic exmem_flush;
        logic halted;
    } outs_t;

    typedef struct {
        string name;
        outs_t exp;
    } exp_t;

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [3:0] fun;
        logic [3:0] rs;
        logic [3:0] rt;
        logic [1:0] mr;
        logic       rw;
        logic [3:0] rd;
        logic       br;
        outs_t      exp;
    } vec_t;

    //                         pc  ifw iff idw idf exf hlt
    localparam outs_t O_NORM  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam outs_t O_STALL = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam outs_t O_FLUSH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam outs_t O_MULB  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam outs_t O_DRAIN = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam outs_t O_HALT  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [15:0] stall_model;
    exp_t sb[$];
    vec_t vecs[$];

    hazard_ctrl_if bus ();

    hazard_ctrl #(
        .MULDIV_CYCLES(4),
        .DRAIN_CYCLES (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish exp finish");
        $fatal(1);
    end

    function automatic vec_t mkv(string nm, logic [3:0] op, logic [3:0] fun,
                                 logic [3:0] rs, logic [3:0] rt, logic [1:0] mr,
                                 logic rw, logic [3:0] rd, logic br, outs_t e);
        vec_t v;
        v.name = nm; v.op = op; v.fun = fun; v.rs = rs; v.rt = rt;
        v.mr = mr; v.rw = rw; v.rd = rd; v.br = br; v.exp = e;
        return v;
    endfunction

    task automatic drv(logic [3:0] op, logic [3:0] fun, logic [3:0] rs, logic [3:0] rt,
                       logic [1:0] mr, logic rw, logic [3:0] rd, logic br);
        bus.id_opCode       = op;
        bus.id_funCode      = fun;
        bus.id_rs           = rs;
        bus.id_rt           = rt;
        bus.ex_memRead      = mr;
        bus.ex_regWrite     = rw;
        bus.ex_rd           = rd;
        bus.ex_branch_taken = br;
    endtask

    task automatic idle();
        drv(4'd1, 4'd0, 4'd1, 4'd2, 2'b00, 1'b0, 4'd0, 1'b0);
    endtask

    // One clock cycle: inputs are already driven; push expectation,
    // compare at the negedge, advance the stall model, move past the edge.
    task automatic cyc(string nm, outs_t e);
        exp_t  x;
        outs_t act;
        logic [15:0] exp_stall;
        x.name = nm;
        x.exp  = e;
        sb.push_back(x);
        @(negedge clk);
        x   = sb.pop_front();
        act = '{bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_write,
                bus.idex_flush, bus.exmem_flush, bus.halted};
        checks++;
        if (act !== x.exp) begin
            errors++;
            $display("FAIL %s: got pc/ifw/iff/idw/idf/exf/hlt=%b exp %b", x.name, act, x.exp);
        end
        exp_stall = PERF ? stall_model : 16'h0000;
        checks++;
        if (bus.stall_cycles !== exp_stall) begin
            errors++;
            $display("FAIL %s_stall: got %0d exp %0d", x.name, bus.stall_cycles, exp_stall);
        end
        if (!x.exp.pc_write && !x.exp.halted && stall_model != 16'hFFFF)
            stall_model = stall_model + 16'd1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        stall_model = 16'd0;
        rst         = 1'b1;
        idle();

        //               name          op    fun   rs    rt    mr     rw    rd    br    expected
        vecs.push_back(mkv("normal",    4'd1, 4'd0, 4'd1, 4'd2, 2'b00, 1'b0, 4'd0, 1'b0, O_NORM));
        vecs.push_back(mkv("lu_rs",     4'd0, 4'd0, 4'd3, 4'd0, 2'b01, 1'b1, 4'd3, 1'b0, O_STALL));
        vecs.push_back(mkv("lu_rt",     4'd2, 4'd0, 4'd1, 4'd6, 2'b01, 1'b1, 4'd6, 1'b0, O_STALL));
        vecs.push_back(mkv("lu_mr10",   4'd3, 4'd0, 4'd9, 4'd2, 2'b10, 1'b1, 4'd9, 1'b0, O_STALL));
        vecs.push_back(mkv("lu_mr11",   4'd5, 4'd0, 4'd4, 4'd4, 2'b11, 1'b1, 4'd4, 1'b0, O_STALL));
        vecs.push_back(mkv("lu_r0",     4'd1, 4'd0, 4'd0, 4'd7, 2'b01, 1'b1, 4'd0, 1'b0, O_STALL));
        vecs.push_back(mkv("no_regwr",  4'd0, 4'd0, 4'd3, 4'd3, 2'b01, 1'b0, 4'd3, 1'b0, O_NORM));
        vecs.push_back(mkv("no_load",   4'd0, 4'd0, 4'd3, 4'd3, 2'b00, 1'b1, 4'd3, 1'b0, O_NORM));
        vecs.push_back(mkv("jmp_nord",  4'd7, 4'd0, 4'd3, 4'd3, 2'b01, 1'b1, 4'd3, 1'b0, O_NORM));
        vecs.push_back(mkv("lu_nomatch",4'd0, 4'd0, 4'd5, 4'd6, 2'b01, 1'b1, 4'd3, 1'b0, O_NORM));
        vecs.push_back(mkv("br_over_lu",4'd0, 4'd0, 4'd3, 4'd0, 2'b01, 1'b1, 4'd3, 1'b1, O_FLUSH));
        vecs.push_back(mkv("br_nomatch",4'd0, 4'd0, 4'd5, 4'd0, 2'b01, 1'b1, 4'd3, 1'b1, O_FLUSH));
        vecs.push_back(mkv("br_jmp",    4'd7, 4'd0, 4'd1, 4'd2, 2'b00, 1'b0, 4'd0, 1'b1, O_FLUSH));
        vecs.push_back(mkv("lu_over_md",4'd0, 4'd4, 4'd8, 4'd2, 2'b01, 1'b1, 4'd8, 1'b0, O_STALL));
        vecs.push_back(mkv("br_over_ht",4'd15,4'd0, 4'd1, 4'd2, 2'b00, 1'b0, 4'd0, 1'b1, O_FLUSH));
        vecs.push_back(mkv("br_over_md",4'd0, 4'd5, 4'd1, 4'd2, 2'b00, 1'b0, 4'd0, 1'b1, O_FLUSH));
        vecs.push_back(mkv("normal2",   4'd0, 4'd6, 4'd1, 4'd2, 2'b00, 1'b0, 4'd0, 1'b0, O_NORM));

        repeat (2) @(posedge clk);
        #1;
        rst         = 1'b0;
        stall_model = 16'd0;
        cyc("reset_state", O_NORM);

        for (int i = 0; i < vecs.size(); i++) begin
            drv(vecs[i].op, vecs[i].fun, vecs[i].rs, vecs[i].rt,
                vecs[i].mr, vecs[i].rw, vecs[i].rd, vecs[i].br);
            cyc(vecs[i].name, vecs[i].exp);
        end

        // Load-use for one cycle, then the load leaves EX.
        drv(4'd0, 4'd0, 4'd3, 4'd0, 2'b01, 1'b1, 4'd3, 1'b0);
        cyc("lu_seq_stall", O_STALL);
        bus.ex_memRead = 2'b00;
        cyc("lu_seq_release", O_NORM);

        // Multiply and divide: issue, exactly three held cycles, back to RUN.
        for (int f = 4; f <= 5; f++) begin
            idle();
            bus.id_opCode  = 4'd0;
            bus.id_funCode = 4'(f);
            cyc("md_issue", O_NORM);
            idle();
            for (int k = 0; k < 3; k++) begin
                bus.ex_branch_taken = (k == 1);
                cyc("md_busy", O_MULB);
            end
            bus.ex_branch_taken = 1'b0;
            cyc("md_return", O_NORM);
            cyc("md_run", O_NORM);
        end

        // Halt: three drain cycles, then halted held until reset.
        drv(4'd15, 4'd0, 4'd3, 4'd3, 2'b01, 1'b1, 4'd3, 1'b0);
        cyc("halt_id", O_DRAIN);
        idle();
        for (int k = 0; k < 3; k++) cyc("halt_drain", O_DRAIN);
        for (int k = 0; k < 20; k++) begin
            bus.ex_branch_taken = (k == 5);
            cyc("halt_hold", O_HALT);
        end
        idle();
        rst = 1'b1;
        cyc("halt_rst_cycle", O_HALT);
        rst         = 1'b0;
        stall_model = 16'd0;
        cyc("halt_after_rst", O_NORM);

        // Wrong-path halt cancelled by a taken branch in the first drain cycle.
        bus.id_opCode = 4'd15;
        cyc("wp_halt_id", O_DRAIN);
        idle();
        bus.ex_branch_taken = 1'b1;
        cyc("wp_flush", O_FLUSH);
        bus.ex_branch_taken = 1'b0;
        for (int k = 0; k < 5; k++) cyc("wp_run", O_NORM);

        // Reset during the second MULBUSY cycle.
        idle();
        bus.id_opCode  = 4'd0;
        bus.id_funCode = 4'd4;
        cyc("mbr_issue", O_NORM);
        idle();
        cyc("mbr_busy1", O_MULB);
        rst = 1'b1;
        cyc("mbr_rst_cycle", O_MULB);
        rst         = 1'b0;
        stall_model = 16'd0;
        cyc("mbr_after_rst", O_NORM);
        cyc("mbr_run", O_NORM);

        // One load-use stall after reset; stall counter then reads one.
        drv(4'd0, 4'd0, 4'd3, 4'd0, 2'b01, 1'b1, 4'd3, 1'b0);
        cyc("perf_stall", O_STALL);
        idle();
        cyc("perf_after", O_NORM);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d left exp 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
